// File: rtl/pedestrian_pkg.sv
// Shared types and defaults for the pedestrian signal array.
package pedestrian_pkg;

    typedef enum logic [1:0] {
        DONT_WALK = 2'b00,
        WALK      = 2'b01,
        CLEARANCE = 2'b10
    } ped_state_e;

    localparam int DEF_NUM_CROSS    = 2;
    localparam int DEF_CLEAR_CYCLES = 10;
    localparam int DEF_BLINK_HALF   = 4;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pedestrian_channel.sv
// One crosswalk: request latch, walk/clearance FSM, clearance timer and lamp decode.
module pedestrian_channel
    import pedestrian_pkg::*;
#(
    parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flash_i,
    input  logic flash_active_i,
    input  logic blink_phase_i,
    input  logic walk_button_i,
    input  logic walk_grant_i,
    output logic hand_o,
    output logic person_o,
    output logic pending_o,
    output logic clear_done_o
);

    localparam int            CW       = cnt_width(CLEAR_CYCLES);
    localparam logic [CW-1:0] CLR_LOAD = CW'(CLEAR_CYCLES - 1);

    ped_state_e    state_q, state_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic          req_q, req_d;
    logic          done_q, done_d;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        req_d     = req_q | walk_button_i;
        done_d    = 1'b0;
        if (flash_i) begin
            state_d   = DONT_WALK;
            clr_cnt_d = '0;
        end else begin
            case (state_q)
                DONT_WALK: begin
                    // Entering WALK serves the request, even one pressed this cycle.
                    if (walk_grant_i && req_q) begin
                        state_d = WALK;
                        req_d   = 1'b0;
                    end
                end
                WALK: begin
                    if (!walk_grant_i) begin
                        state_d   = CLEARANCE;
                        clr_cnt_d = CLR_LOAD;
                    end
                end
                CLEARANCE: begin
                    if (clr_cnt_q == '0) begin
                        state_d = DONT_WALK;
                        done_d  = 1'b1;
                    end else begin
                        clr_cnt_d = clr_cnt_q - CW'(1);
                    end
                end
                default: state_d = DONT_WALK;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DONT_WALK;
            clr_cnt_q <= '0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            req_q     <= req_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        hand_o   = 1'b1;
        person_o = 1'b0;
        case (state_q)
            DONT_WALK: hand_o = flash_active_i ? blink_phase_i : 1'b1;
            WALK: begin
                hand_o   = 1'b0;
                person_o = 1'b1;
            end
            CLEARANCE: hand_o = blink_phase_i;
            default:   hand_o = 1'b1;
        endcase
    end

    assign pending_o    = req_q;
    assign clear_done_o = done_q;

endmodule

// File: rtl/pedestrian_signal_array.sv
// Array of independent pedestrian crosswalk signals sharing one blink generator.
module pedestrian_signal_array
    import pedestrian_pkg::*;
#(
    parameter int NUM_CROSS    = DEF_NUM_CROSS,
    parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES,
    parameter int BLINK_HALF   = DEF_BLINK_HALF
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 flashMode,
    input  logic [NUM_CROSS-1:0] walkButton,
    input  logic [NUM_CROSS-1:0] walkGrant,
    output logic [NUM_CROSS-1:0] handLED,
    output logic [NUM_CROSS-1:0] personLED,
    output logic [NUM_CROSS-1:0] requestPending,
    output logic [NUM_CROSS-1:0] clearDone
);

    localparam int            BW         = cnt_width(BLINK_HALF);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic          flash_q;

    always_comb begin
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // flash_q keeps the lamp decode off the flashMode input path.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            flash_q       <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            flash_q       <= flashMode;
        end
    end

    for (genvar i = 0; i < NUM_CROSS; i++) begin : g_ch
        pedestrian_channel #(
            .CLEAR_CYCLES(CLEAR_CYCLES)
        ) u_ch (
            .clk           (clk),
            .rst_n         (resetN),
            .flash_i       (flashMode),
            .flash_active_i(flash_q),
            .blink_phase_i (blink_phase_q),
            .walk_button_i (walkButton[i]),
            .walk_grant_i  (walkGrant[i]),
            .hand_o        (handLED[i]),
            .person_o      (personLED[i]),
            .pending_o     (requestPending[i]),
            .clear_done_o  (clearDone[i])
        );
    end

endmodule

// File: tb/tb_pedestrian_signal_array.sv
// Scoreboard bench: the driver queues per-edge expectations, the monitor checks them.
module tb_pedestrian_signal_array;

    logic       clk = 1'b0;
    logic       resetN;
    logic       flashMode;
    logic [1:0] walkButton, walkGrant;
    logic [1:0] handLED, personLED, requestPending, clearDone;

    typedef struct {
        int         id;
        logic [1:0] hand;
        logic [1:0] person;
        logic [1:0] pend;
        logic [1:0] done;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   edge_n = 0;

    always #5 clk = ~clk;

    pedestrian_signal_array dut (
        .clk           (clk),
        .resetN        (resetN),
        .flashMode     (flashMode),
        .walkButton    (walkButton),
        .walkGrant     (walkGrant),
        .handLED       (handLED),
        .personLED     (personLED),
        .requestPending(requestPending),
        .clearDone     (clearDone)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Blink phase after k edges since reset with BLINK_HALF=4: starts 1, flips every 4 edges.
    function automatic logic blink_at(input int k);
        return (((k / 4) % 2) == 0) ? 1'b1 : 1'b0;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the coming edge.
    // Bits set in hmask expect handLED to equal the blink phase at that edge.
    task automatic step(input logic [1:0] btn, input logic [1:0] grant, input logic flash,
                        input logic [1:0] hand, input logic [1:0] hmask,
                        input logic [1:0] person, input logic [1:0] pend,
                        input logic [1:0] done);
        exp_t e;
        @(negedge clk);
        walkButton = btn;
        walkGrant  = grant;
        flashMode  = flash;
        edge_n++;
        e.id     = edge_n;
        e.hand   = (hand & ~hmask) | (blink_at(edge_n) ? hmask : 2'b00);
        e.person = person;
        e.pend   = pend;
        e.done   = done;
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check($sformatf("e%0d hand", e.id), 32'(handLED), 32'(e.hand));
                check($sformatf("e%0d person", e.id), 32'(personLED), 32'(e.person));
                check($sformatf("e%0d pending", e.id), 32'(requestPending), 32'(e.pend));
                check($sformatf("e%0d clearDone", e.id), 32'(clearDone), 32'(e.done));
                check($sformatf("e%0d hand&person", e.id), 32'(handLED & personLED), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        resetN     = 1'b0;
        flashMode  = 1'b0;
        walkButton = 2'b00;
        walkGrant  = 2'b00;
        repeat (3) @(posedge clk);
        #2;
        check("reset hand", 32'(handLED), 32'h3);
        check("reset person", 32'(personLED), 32'h0);
        check("reset pending", 32'(requestPending), 32'h0);
        check("reset clearDone", 32'(clearDone), 32'h0);
        resetN = 1'b1;

        // Idle after reset: edges 1..20.
        for (int i = 0; i < 20; i++) step(2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);

        // Button on ch0, grant three cycles later together with a second press.
        step(2'b01, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00);          // 21
        for (int i = 0; i < 2; i++)
            step(2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00);      // 22-23
        step(2'b01, 2'b01, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00);          // 24 WALK
        for (int i = 0; i < 2; i++)
            step(2'b00, 2'b01, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00);      // 25-26

        // Clearance on ch0: 10 blinking cycles, grant re-asserted mid-way is ignored.
        for (int i = 0; i < 3; i++)
            step(2'b00, 2'b00, 1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00);      // 27-29
        for (int i = 0; i < 2; i++)
            step(2'b00, 2'b01, 1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00);      // 30-31
        for (int i = 0; i < 5; i++)
            step(2'b00, 2'b00, 1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00);      // 32-36
        step(2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01);          // 37 done
        step(2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);          // 38

        // ch1 into WALK, then ch0 WALK while ch1 clears, then flash mode.
        step(2'b10, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00);          // 39
        step(2'b00, 2'b10, 1'b0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00);          // 40
        step(2'b01, 2'b10, 1'b0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00);          // 41
        step(2'b00, 2'b01, 1'b0, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00);          // 42
        step(2'b00, 2'b01, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00);          // 43
        step(2'b10, 2'b01, 1'b1, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00);          // 44 flash
        for (int i = 0; i < 5; i++)
            step(2'b00, 2'b00, 1'b1, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00);      // 45-49
        step(2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00);          // 50

        // ch1 into CLEARANCE, then asynchronous reset between edges.
        step(2'b00, 2'b10, 1'b0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00);          // 51
        step(2'b00, 2'b00, 1'b0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00);          // 52
        step(2'b00, 2'b00, 1'b0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00);          // 53
        @(posedge clk);
        #3;
        check("scoreboard drained before reset", 32'(sb_q.size()), 32'd0);
        resetN = 1'b0;
        #1;
        check("async reset hand", 32'(handLED), 32'h3);
        check("async reset person", 32'(personLED), 32'h0);
        check("async reset pending", 32'(requestPending), 32'h0);
        check("async reset clearDone", 32'(clearDone), 32'h0);
        repeat (2) @(posedge clk);
        #2;
        resetN = 1'b1;
        edge_n = 0;
        for (int i = 0; i < 12; i++) step(2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);

        @(posedge clk);
        #3;
        check("scoreboard drained at end", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pedestrian_signal_array.md
PEDESTRIAN_SIGNAL_ARRAY -- requirements
Module: pedestrian_signal_array

Interface
REQ-001 Parameter NUM_CROSS, default 2, number of independent crosswalk channels (1..8).
REQ-002 Parameter CLEAR_CYCLES, default 10, clearance (blinking-hand) duration in clock cycles (>=1).
REQ-003 Parameter BLINK_HALF, default 4, cycles per blink half-period (>=1).
REQ-004 clk  input  1  single system clock, all state updates on rising edge.
REQ-005 resetN  input  1  reset, asynchronous, active-low.
REQ-006 flashMode  input  1  night/fault mode, all channels blink hand, person dark.
REQ-007 walkButton  input  NUM_CROSS  per-channel pedestrian push-button, level-sampled each cycle.
REQ-008 walkGrant  input  NUM_CROSS  per-channel walk permission from the intersection FSM.
REQ-009 handLED  output  NUM_CROSS  per-channel "don't walk" lamp.
REQ-010 personLED  output  NUM_CROSS  per-channel "walk" lamp.
REQ-011 requestPending  output  NUM_CROSS  per-channel latched, not-yet-served request.
REQ-012 clearDone  output  NUM_CROSS  per-channel one-cycle pulse when clearance completes.

Function
REQ-013 Shared blink generator: counter 0..BLINK_HALF-1; blinkPhase toggles on the edge where counter equals BLINK_HALF-1, counter wraps to 0.
REQ-014 Request latch: walkButton[i]=1 at an edge sets requestPending[i]; cleared on the edge entering WALK; simultaneous set and WALK entry -> cleared (request served).
REQ-015 Per-channel states DONT_WALK, WALK, CLEARANCE.
REQ-016 DONT_WALK -> WALK when walkGrant[i]=1 and requestPending[i]=1 and flashMode=0; otherwise hold.
REQ-017 WALK -> CLEARANCE when walkGrant[i]=0; clearance counter loaded with CLEAR_CYCLES-1.
REQ-018 CLEARANCE: counter decrements each cycle; at 0 -> DONT_WALK on the next edge; total CLEARANCE residency exactly CLEAR_CYCLES cycles.
REQ-019 walkGrant re-assertion during CLEARANCE ignored; clearance always completes.
REQ-020 clearDone[i] high for exactly the first cycle after CLEARANCE -> DONT_WALK.
REQ-021 Output decode: DONT_WALK hand=1 person=0; WALK hand=0 person=1; CLEARANCE hand=blinkPhase person=0.
REQ-022 Never hand=1 and person=1 simultaneously on any channel.
REQ-023 flashMode=1: every channel forced to DONT_WALK on next edge (no clearDone), outputs hand=blinkPhase person=0; request latching continues.
REQ-024 Outputs depend only on registered state and blinkPhase; no combinational input-to-output path.
REQ-025 Channels fully independent; any mix of states legal.

Reset
REQ-026 resetN=0 asynchronously forces: all channels DONT_WALK, handLED all 1, personLED all 0, requestPending 0, clearDone 0, clearance counters 0, blink counter 0, blinkPhase 1.
REQ-027 Reset mid-WALK or mid-CLEARANCE abandons the phase; no clearDone emitted.
REQ-028 First state change earliest at first rising clk edge after resetN deasserts.

Structure
REQ-029 Shared package pedestrian_pkg holds the state typedef (DONT_WALK=2'b00, WALK=2'b01, CLEARANCE=2'b10) and default parameter constants.
REQ-030 Sub-module pedestrian_channel (one FSM, request latch, clearance counter, output decode) instantiated NUM_CROSS times; blink generator lives in the top.
REQ-031 Counter widths derived from parameters via clog2, minimum 1 bit.

Verification
REQ-032 Reset then idle 20 cycles, NUM_CROSS=2 -> handLED=2'b11, personLED=2'b00, requestPending=2'b00 throughout.
REQ-033 Pulse walkButton[0] 1 cycle, walkGrant[0]=1 three cycles later -> requestPending[0] set next edge, WALK (person[0]=1) one edge after grant, pending cleared; channel 1 unchanged.
REQ-034 Drop walkGrant[0] in WALK, CLEAR_CYCLES=10, BLINK_HALF=4 -> hand[0] toggles every 4 cycles for 10 cycles, then solid 1, clearDone[0] one-cycle pulse.
REQ-035 Re-assert walkGrant[0] mid-CLEARANCE and press button same cycle as WALK entry -> clearance completes unchanged; pending ends 0.
REQ-036 flashMode=1 while channel 0 WALK, channel 1 CLEARANCE -> both DONT_WALK next edge, hand both =blinkPhase, person 0, no clearDone.
REQ-037 resetN low asynchronously mid-CLEARANCE (between edges) -> outputs reset values immediately, no clearDone after release.
